lfsr_16bit_checker: RTL
=======================

Name: lfsr_16bit_checker

Overview:
- Receive-side PRBS checker for the 16-bit XNOR LFSR stream used by the pseudo-random replacement/test generators.
- Taps 15, 12, 5, 1, shifting left with the new bit in the LSB.
- Consumes the serial bit stream (generator's shift-in bit per enabled cycle) and self-synchronises by loading 16 received bits.
- Once locked, predicts each following bit and flags and counts mismatches; used in link/BIST loopback and for verifying LFSR-driven replacement paths.

Parameters:
- ERR_THRESH, 4: mismatches within one window that cause loss of lock (range 1..WINDOW).
- WINDOW, 64: valid bits per error-evaluation window (power of two, at least 2).
- CNT_WIDTH, 16: width of the saturating total-error counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- en_i  in  1  data_i valid this cycle.
- data_i  in  1  received PRBS bit.
- clear_i  in  1  synchronous clear of err_cnt_o.
- locked_o  out  1  checker is in LOCKED state.
- err_o  out  1  one-cycle pulse: previous valid bit mismatched.
- err_cnt_o  out  CNT_WIDTH  total mismatches since reset/clear, saturating.

Behaviour:
- Single clock domain. All state updates only on rising clk_i.
- Reset: rst_ni low at a clock edge (synchronous, active-low) forces the following values:
  - state SEARCH;
  - shift register 16'h0000;
  - fill count 0; window count 0; window-error count 0;
  - locked_o 0, err_o 0, err_cnt_o 0.
- Reset mid-operation discards lock and all counts.
- en_i low: no register changes except err_o <= 0 and clear_i handling.
- Expected bit: exp = NOT(s[15] XOR s[12] XOR s[5] XOR s[1]), where s is the current shift register.
- SEARCH, en_i high:
  - s <= {s[14:0], data_i}; fill count increments.
  - On the 16th valid bit (fill count == 15):
    - if the new s == 16'hFFFF (XNOR lockup value, not a legal generator state): fill count <= 0, stay in SEARCH;
    - otherwise go to LOCKED with fill count, window count and window-error count cleared.
  - err_o stays 0 in SEARCH; err_cnt_o is unchanged.
- locked_o is a registered output: it rises the cycle after the 16th valid bit.
- LOCKED, en_i high:
  - s <= {s[14:0], exp}; the predicted bit is shifted in so a single error does not propagate.
  - mismatch = (data_i != exp); err_o <= mismatch, i.e. the pulse appears one cycle after the offending bit.
  - On mismatch, err_cnt_o increments and saturates at all-ones.
  - Window count increments and wraps at WINDOW-1 -> 0; on mismatch the window-error count increments.
  - If that increment makes the window-error count equal ERR_THRESH: next state SEARCH, fill count 0, window counters 0. locked_o falls the next cycle; err_o still pulses for that bit.
  - Else if the window count wraps on this bit: window-error count <= 0, evaluated after the threshold check.
- clear_i:
  - err_cnt_o <= 0, or 1 if a counted mismatch occurs in the same cycle.
  - Does not affect state, locked_o or the window counters.
- Saturation: at 2^CNT_WIDTH-1, further mismatches still pulse err_o but leave the count unchanged.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then feed the seed-0 generator stream (first bits 1,1,0,0,1,1,1,...) with en_i always high -> locked_o rises on the cycle after the 16th bit; err_o stays 0 and err_cnt_o stays 0 over 1000 bits.
- Locked, flip one bit -> err_o high exactly one cycle after it; err_cnt_o = 1; following bits give no errors (no propagation); locked_o stays 1.
- Locked, inject 4 flips within 64 bits -> err_cnt_o = 4; locked_o falls the cycle after the 4th; resumes lock 16 valid bits later.
- Inject 3 flips in one window and 1 in the next window -> lock retained, err_cnt_o = 4.
- Feed 16 ones in SEARCH -> stays SEARCH (FFFF rejected); then a legal stream -> locks after 16 more bits.
- Gapped en_i (1 valid bit in 3), CNT_WIDTH=2 with 5 errors (threshold raised) -> lock timing counts valid bits only; err_cnt_o saturates at 3.
- Assert clear_i together with a mismatch -> err_cnt_o = 1.
- Assert rst_ni low mid-lock -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/lfsr_16bit_checker_if.sv
// Bundle of the data-path and status signals between a PRBS source/observer
// (master) and the 16-bit XNOR LFSR checker (slave).
interface lfsr_16bit_checker_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic                 en_i;
  logic                 data_i;
  logic                 clear_i;
  logic                 locked_o;
  logic                 err_o;
  logic [CNT_WIDTH-1:0] err_cnt_o;

  modport master (
    output en_i,
    output data_i,
    output clear_i,
    input  locked_o,
    input  err_o,
    input  err_cnt_o
  );

  modport slave (
    input  en_i,
    input  data_i,
    input  clear_i,
    output locked_o,
    output err_o,
    output err_cnt_o
  );
endinterface

// File: rtl/lfsr_16bit_checker.sv
// Receive-side checker for the 16-bit XNOR LFSR PRBS (taps 15,12,5,1, shift
// left, new bit in LSB). Self-synchronises by loading 16 received bits, then
// predicts every following bit, flagging and counting mismatches. Too many
// mismatches inside one evaluation window drop the lock and restart the
// search.
module lfsr_16bit_checker #(
  parameter int ERR_THRESH = 4,
  parameter int WINDOW     = 64,
  parameter int CNT_WIDTH  = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  lfsr_16bit_checker_if.slave bus
);

  localparam int WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int WERR_W = $clog2(WINDOW + 1);

  localparam logic [WERR_W-1:0]    THRESH_V = WERR_W'(ERR_THRESH);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [15:0]          r_shift;
  logic [15:0]          w_shift_next;
  logic [3:0]           r_fill;
  logic [3:0]           w_fill_next;
  logic [WIN_W-1:0]     r_win_cnt;
  logic [WIN_W-1:0]     w_win_cnt_next;
  logic [WERR_W-1:0]    r_win_err;
  logic [WERR_W-1:0]    w_win_err_next;
  logic [WERR_W-1:0]    w_win_err_inc;
  logic                 r_locked;
  logic                 r_err;
  logic                 w_err_next;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0] w_err_cnt_next;

  logic                 w_exp;
  logic                 w_mismatch;
  logic                 w_wrap;
  logic [15:0]          w_load_shift;

  // Predicted next bit of the generator given the last 16 bits held.
  assign w_exp        = ~(r_shift[15] ^ r_shift[12] ^ r_shift[5] ^ r_shift[1]);
  // Shift register value if the received bit is loaded (search mode).
  assign w_load_shift = {r_shift[14:0], bus.data_i};
  assign w_mismatch   = (r_state == ST_LOCKED) && bus.en_i && (bus.data_i != w_exp);
  assign w_wrap       = (r_win_cnt == WIN_LAST);
  assign w_win_err_inc = r_win_err + WERR_W'(w_mismatch);

  // Next-state logic: search/fill, lockup rejection, prediction and window-based loss of lock.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_fill_next    = r_fill;
    w_win_cnt_next = r_win_cnt;
    w_win_err_next = r_win_err;
    w_err_next     = 1'b0;

    case (r_state)
      ST_SEARCH: begin
        if (bus.en_i) begin
          w_shift_next = w_load_shift;
          if (r_fill == 4'd15) begin
            w_fill_next = 4'd0;
            // All-ones is the XNOR lockup value and never a real generator state.
            if (w_load_shift != 16'hFFFF) begin
              w_state_next   = ST_LOCKED;
              w_win_cnt_next = '0;
              w_win_err_next = '0;
            end
          end else begin
            w_fill_next = r_fill + 4'd1;
          end
        end
      end

      ST_LOCKED: begin
        if (bus.en_i) begin
          // Shift in the prediction so a corrupted bit cannot poison later predictions.
          w_shift_next   = {r_shift[14:0], w_exp};
          w_err_next     = w_mismatch;
          w_win_cnt_next = r_win_cnt + WIN_W'(1);
          if (w_mismatch && (w_win_err_inc == THRESH_V)) begin
            w_state_next   = ST_SEARCH;
            w_fill_next    = 4'd0;
            w_win_cnt_next = '0;
            w_win_err_next = '0;
          end else if (w_wrap) begin
            w_win_err_next = '0;
          end else begin
            w_win_err_next = w_win_err_inc;
          end
        end
      end

      default: begin
        w_state_next = ST_SEARCH;
        w_fill_next  = 4'd0;
      end
    endcase
  end

  // Total error counter: saturating, clear wins but still records a same-cycle mismatch.
  always_comb begin
    w_err_cnt_next = r_err_cnt;
    if (bus.clear_i) begin
      w_err_cnt_next = w_mismatch ? CNT_WIDTH'(1) : '0;
    end else if (w_mismatch && (r_err_cnt != CNT_MAX)) begin
      w_err_cnt_next = r_err_cnt + CNT_WIDTH'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_SEARCH;
      r_shift   <= 16'h0000;
      r_fill    <= 4'd0;
      r_win_cnt <= '0;
      r_win_err <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_fill    <= w_fill_next;
      r_win_cnt <= w_win_cnt_next;
      r_win_err <= w_win_err_next;
      r_locked  <= (w_state_next == ST_LOCKED);
      r_err     <= w_err_next;
      r_err_cnt <= w_err_cnt_next;
    end
  end

  assign bus.locked_o  = r_locked;
  assign bus.err_o     = r_err;
  assign bus.err_cnt_o = r_err_cnt;

endmodule
